axis_pixel_packer: RTL and testbench

- Upstream neighbour of the frame-fetch stage.
- Takes a sensor-side pixel stream of one pixel per handshake and packs it into full-width AXI-Stream beats for the frame-fetch AXI-Stream slave.
- Marks the last beat of each frame with tlast.
- Steers each whole frame to one image processor through tdest, advancing round-robin per frame.
- A 2-entry output buffer decouples pixel intake from downstream back-pressure.

---
 rtl/axis_pixel_packer.sv | 253 +++++++++++++++++++++++++
 tb/tb_axis_pixel_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixel_packer.sv
// ============================================================================
// Module   : axis_pixel_packer
// Brief    : Packs a one-pixel-per-handshake sensor stream into full-width
//            AXI-Stream beats. Marks the last beat of each frame with tlast
//            and steers whole frames round-robin across image processors
//            via tdest. A 2-entry output buffer decouples pixel intake from
//            downstream back-pressure.
// Options  : PACKER_STAT_EN - adds frame_cnt_o / err_cnt_o statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pixel_packer #(
  parameter int IP_AMT       = 1,
  parameter int IP_ADDR_W    = $clog2(IP_AMT),
  parameter int AXIS_TDEST_W = (IP_ADDR_W > 1) ? IP_ADDR_W : 1,
  parameter int AXIS_TID_W   = 2,
  parameter int AXIS_TID_VAL = 0,
  parameter int IP_DATA_W    = 256,
  parameter int PIXEL_W      = 8,
  parameter int FRAME_PIX    = 76800
) (
  input  logic                      s_aclk,
  input  logic                      s_aresetn,
  // sensor-side pixel stream
  input  logic [PIXEL_W-1:0]        pixel_i,
  input  logic                      pixel_sof_i,
  input  logic                      pixel_valid_i,
  output logic                      pixel_ready_o,
  // AXI-Stream master towards frame fetch
  output logic [AXIS_TID_W-1:0]     m_tid_o,
  output logic [AXIS_TDEST_W-1:0]   m_tdest_o,
  output logic [IP_DATA_W-1:0]      m_tdata_o,
  output logic [IP_DATA_W/8-1:0]    m_tkeep_o,
  output logic [IP_DATA_W/8-1:0]    m_tstrb_o,
  output logic                      m_tlast_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  // status
  output logic                      frame_err_o
`ifdef PACKER_STAT_EN
  ,
  output logic [15:0]               frame_cnt_o,
  output logic [15:0]               err_cnt_o
`endif
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int PIX_PER_BEAT    = IP_DATA_W / PIXEL_W;
  localparam int BEATS_PER_FRAME = FRAME_PIX / PIX_PER_BEAT;
  localparam int LANE_W          = (PIX_PER_BEAT > 1)    ? $clog2(PIX_PER_BEAT)    : 1;
  localparam int BEAT_W          = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;

  localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(PIX_PER_BEAT - 1);
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);

  // Packing state machine encoding
  localparam logic [0:0] ST_IDLE = 1'b0;  // waiting for a start-of-frame pixel
  localparam logic [0:0] ST_PACK = 1'b1;  // filling beats of the current frame

  // --------------------------------------------------------------------------
  // Packing state
  // --------------------------------------------------------------------------
  logic [0:0]              r_state;
  logic [LANE_W-1:0]       r_lane;
  logic [BEAT_W-1:0]       r_beat;
  logic [IP_DATA_W-1:0]    r_word;
  logic [AXIS_TDEST_W-1:0] r_tdest;
  logic [AXIS_TDEST_W-1:0] r_next_tdest;
  logic                    r_frame_err;

  // --------------------------------------------------------------------------
  // Two-entry output buffer (ring of two slots)
  // --------------------------------------------------------------------------
  logic [IP_DATA_W-1:0]    r_buf_data [2];
  logic                    r_buf_last [2];
  logic [AXIS_TDEST_W-1:0] r_buf_dest [2];
  logic                    r_rd_ptr;
  logic                    r_wr_ptr;
  logic [1:0]              r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                    w_pop;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_active;
  logic                    w_restart;
  logic                    w_push;
  logic [LANE_W-1:0]       w_lane_eff;
  logic [BEAT_W-1:0]       w_beat_eff;
  logic [AXIS_TDEST_W-1:0] w_dest_eff;
  logic [AXIS_TDEST_W-1:0] w_dest_inc;
  logic                    w_last_lane;
  logic                    w_last_beat;
  logic [IP_DATA_W-1:0]    w_word;

  // The output side only depends on registered occupancy, so tvalid never
  // sees a combinational path from tready.
  assign w_pop    = (r_count != 2'd0) & m_tready_i;

  // A same-cycle pop frees a slot, so intake continues at full rate with a
  // full buffer as long as the consumer is draining.
  assign w_ready  = (r_count != 2'd2) | w_pop;
  assign w_accept = pixel_valid_i & w_ready;

  // A pixel takes part in packing if it starts a frame or arrives mid-frame;
  // pre-sof junk in IDLE is simply dropped.
  assign w_active  = w_accept & (pixel_sof_i | (r_state == ST_PACK));

  // A sof inside a frame that already holds pixels aborts that frame.
  assign w_restart = w_accept & pixel_sof_i & (r_state == ST_PACK) &
                     ((r_lane != '0) | (r_beat != '0));

  // A sof pixel always becomes lane 0 of beat 0.
  assign w_lane_eff  = pixel_sof_i ? '0 : r_lane;
  assign w_beat_eff  = pixel_sof_i ? '0 : r_beat;

  // New frames take the round-robin target; restarts keep the current one.
  assign w_dest_eff  = (r_state == ST_IDLE) ? r_next_tdest : r_tdest;

  assign w_last_lane = (w_lane_eff == C_LAST_LANE);
  assign w_last_beat = (w_beat_eff == C_LAST_BEAT);
  assign w_push      = w_active & w_last_lane;

  // Round-robin successor of the current frame target
  generate
    if (IP_AMT <= 1) begin : g_rr_single
      assign w_dest_inc = '0;
    end else begin : g_rr_multi
      localparam logic [AXIS_TDEST_W-1:0] C_LAST_DEST = AXIS_TDEST_W'(IP_AMT - 1);
      assign w_dest_inc = (w_dest_eff == C_LAST_DEST) ? '0 : w_dest_eff + 1'b1;
    end
  endgenerate

  // Merge the incoming pixel into its lane; first pixel lands in the LSBs.
  always_comb begin
    w_word = r_word;
    w_word[int'(w_lane_eff) * PIXEL_W +: PIXEL_W] = pixel_i;
  end

  // --------------------------------------------------------------------------
  // Frame/lane/beat tracking and round-robin target selection
  // --------------------------------------------------------------------------
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_beat       <= '0;
      r_word       <= '0;
      r_tdest      <= '0;
      r_next_tdest <= '0;
    end else if (w_active) begin
      r_tdest <= w_dest_eff;
      if (w_push) begin
        r_lane <= '0;
        if (w_last_beat) begin
          r_beat       <= '0;
          r_next_tdest <= w_dest_inc;
          r_state      <= ST_IDLE;
        end else begin
          r_beat  <= w_beat_eff + 1'b1;
          r_state <= ST_PACK;
        end
      end else begin
        r_word  <= w_word;
        r_lane  <= w_lane_eff + 1'b1;
        r_beat  <= w_beat_eff;
        r_state <= ST_PACK;
      end
    end
  end

  // One-cycle error pulse for an aborted frame
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_restart;
    end
  end

  // Output buffer: push completed beats, pop on handshake
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
        r_buf_dest[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_word;
        r_buf_last[r_wr_ptr] <= w_last_beat;
        r_buf_dest[r_wr_ptr] <= w_dest_eff;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pixel_ready_o = w_ready;
  assign m_tvalid_o    = (r_count != 2'd0);
  assign m_tdata_o     = r_buf_data[r_rd_ptr];
  assign m_tlast_o     = r_buf_last[r_rd_ptr];
  assign m_tdest_o     = r_buf_dest[r_rd_ptr];
  assign m_tid_o       = AXIS_TID_W'(AXIS_TID_VAL);
  assign m_tkeep_o     = '1;
  assign m_tstrb_o     = '1;
  assign frame_err_o   = r_frame_err;

`ifdef PACKER_STAT_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  // Completed frames (wrapping) and aborted frames (saturating)
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      if (w_pop && m_tlast_o) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (r_frame_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign err_cnt_o   = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_pixel_packer.sv
// ============================================================================
// Module   : tb_axis_pixel_packer
// Brief    : Self-checking bench for axis_pixel_packer (64-pixel frames,
//            two image processors). Expected beats come from a frame-level
//            reference model that collects pixels per frame and slices them
//            into beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_pixel_packer;

  localparam int IP_AMT    = 2;
  localparam int FRAME_PIX = 64;
  localparam int PIXEL_W   = 8;
  localparam int IP_DATA_W = 256;
  localparam int PPB       = IP_DATA_W / PIXEL_W;

  logic                 s_aclk = 1'b0;
  logic                 s_aresetn = 1'b0;
  logic [PIXEL_W-1:0]   pixel_i = '0;
  logic                 pixel_sof_i = 1'b0;
  logic                 pixel_valid_i = 1'b0;
  logic                 pixel_ready_o;
  logic [1:0]           m_tid_o;
  logic [0:0]           m_tdest_o;
  logic [IP_DATA_W-1:0] m_tdata_o;
  logic [31:0]          m_tkeep_o;
  logic [31:0]          m_tstrb_o;
  logic                 m_tlast_o;
  logic                 m_tvalid_o;
  logic                 m_tready_i = 1'b0;
  logic                 frame_err_o;

  axis_pixel_packer #(
    .IP_AMT    (IP_AMT),
    .IP_DATA_W (IP_DATA_W),
    .PIXEL_W   (PIXEL_W),
    .FRAME_PIX (FRAME_PIX)
  ) dut (
    .s_aclk        (s_aclk),
    .s_aresetn     (s_aresetn),
    .pixel_i       (pixel_i),
    .pixel_sof_i   (pixel_sof_i),
    .pixel_valid_i (pixel_valid_i),
    .pixel_ready_o (pixel_ready_o),
    .m_tid_o       (m_tid_o),
    .m_tdest_o     (m_tdest_o),
    .m_tdata_o     (m_tdata_o),
    .m_tkeep_o     (m_tkeep_o),
    .m_tstrb_o     (m_tstrb_o),
    .m_tlast_o     (m_tlast_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i),
    .frame_err_o   (frame_err_o)
  );

  always #5 s_aclk = ~s_aclk;

  // --------------------------------------------------------------------------
  // Reference model: pixels of the frame in progress; every PPB pixels one
  // beat is produced; the beat that completes FRAME_PIX pixels carries tlast.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [IP_DATA_W-1:0] data;
    logic                 last;
    int                   dest;
  } beat_t;

  beat_t        exp_q[$];
  logic [7:0]   frame_px[$];
  bit           in_frame;
  int           next_dest;
  int           cur_dest;
  bit           err_pend;
  int           rdy_pct;
  int           n_assert;
  int           n_fail;

  function automatic void model_reset();
    exp_q.delete();
    frame_px.delete();
    in_frame  = 0;
    next_dest = 0;
    cur_dest  = 0;
    err_pend  = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] px, input logic sof);
    beat_t b;
    int    base;
    if (sof) begin
      if (in_frame) err_pend = 1;
      else cur_dest = next_dest;
      in_frame = 1;
      frame_px.delete();
    end else if (!in_frame) begin
      return;
    end
    frame_px.push_back(px);
    if (frame_px.size() % PPB == 0) begin
      base   = frame_px.size() - PPB;
      b.data = '0;
      for (int i = 0; i < PPB; i++) b.data[i*PIXEL_W +: PIXEL_W] = frame_px[base + i];
      b.last = (frame_px.size() == FRAME_PIX);
      b.dest = cur_dest;
      exp_q.push_back(b);
      if (b.last) begin
        in_frame  = 0;
        next_dest = (cur_dest + 1) % IP_AMT;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [IP_DATA_W-1:0] obs,
                       input logic [IP_DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, sample 1 ns before the posedge.
  task automatic tick(input logic pv, input logic [7:0] px, input logic sof,
                      output bit acc);
    bit exp_pop;
    pixel_valid_i = pv;
    pixel_i       = px;
    pixel_sof_i   = sof;
    m_tready_i    = ($urandom_range(0, 99) < rdy_pct);
    #4;
    exp_pop = (exp_q.size() != 0) && m_tready_i;
    check("tvalid", m_tvalid_o, exp_q.size() != 0);
    check("pixel_ready", pixel_ready_o, (exp_q.size() < 2) || exp_pop);
    check("frame_err", frame_err_o, err_pend);
    if (exp_q.size() != 0 && m_tvalid_o) begin
      check("tdata", m_tdata_o, exp_q[0].data);
      check("tlast", m_tlast_o, exp_q[0].last);
      check("tdest", m_tdest_o, exp_q[0].dest);
    end
    if (exp_pop) void'(exp_q.pop_front());
    err_pend = 0;
    acc = pv && pixel_ready_o;
    if (acc) model_accept(px, sof);
    @(negedge s_aclk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic send_pixel(input logic [7:0] px, input logic sof, input int gap_pct);
    bit acc;
    int guard;
    guard = 0;
    acc   = 0;
    while (!acc && guard < 300) begin
      if ($urandom_range(0, 99) < gap_pct) tick(1'b0, 8'h00, 1'b0, acc);
      else tick(1'b1, px, sof, acc);
      guard++;
    end
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_seq(input int start, input int n, input bit sof_first,
                          input bit rnd, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      send_pixel(rnd ? 8'($urandom) : 8'(start + i), sof_first && (i == 0), gap_pct);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    rdy_pct = 100;
    while (exp_q.size() != 0 && g < 500) begin
      idle(1);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  // Safety net against a hung handshake
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    n_assert = 0;
    n_fail   = 0;
    rdy_pct  = 100;
    model_reset();

    // Reset values
    @(negedge s_aclk);
    @(negedge s_aclk);
    check("rst_tvalid", m_tvalid_o, 1'b0);
    check("rst_tlast", m_tlast_o, 1'b0);
    check("rst_tdata", m_tdata_o, '0);
    check("rst_tdest", m_tdest_o, 1'b0);
    check("rst_frame_err", frame_err_o, 1'b0);
    check("rst_tid", m_tid_o, 2'd0);
    check("rst_tkeep", m_tkeep_o, 32'hFFFF_FFFF);
    check("rst_tstrb", m_tstrb_o, 32'hFFFF_FFFF);
    s_aresetn = 1'b1;
    idle(2);

    // Basic frame, then two more for round-robin tdest 0,1,0
    send_seq(0, 64, 1'b1, 1'b0, 0);
    idle(3);
    send_seq(8'h40, 64, 1'b1, 1'b0, 0);
    send_seq(8'h80, 64, 1'b1, 1'b0, 0);
    drain();

    // Back-pressure: two beats stall, intake must stop, then drain in order
    rdy_pct = 0;
    send_seq(8'hC0, 64, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) tick(1'b1, 8'h11, 1'b1, acc);
    rdy_pct = 100;
    send_seq(8'h11, 64, 1'b1, 1'b0, 0);
    drain();

    // Restart on the 40th pixel: one error pulse, new frame keeps tdest
    send_seq(8'h20, 39, 1'b1, 1'b0, 0);
    send_seq(8'h90, 64, 1'b1, 1'b0, 0);
    drain();

    // Pre-sof junk is discarded, following frame packs normally
    send_seq(8'hE0, 10, 1'b0, 1'b0, 0);
    idle(3);
    send_seq(8'h05, 64, 1'b1, 1'b0, 0);
    drain();

    // Reset mid-frame
    send_seq(8'h30, 20, 1'b1, 1'b0, 0);
    s_aresetn = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid_o, 1'b0);
    check("midrst_frame_err", frame_err_o, 1'b0);
    model_reset();
    @(negedge s_aclk);
    @(negedge s_aclk);
    s_aresetn = 1'b1;
    idle(1);
    send_seq(8'h70, 64, 1'b1, 1'b0, 0);
    drain();

    // Randomized frames with random gaps, back-pressure and restarts
    for (int f = 0; f < 12; f++) begin
      rdy_pct = $urandom_range(20, 100);
      if ($urandom_range(0, 3) == 0) send_seq(0, $urandom_range(1, 63), 1'b1, 1'b1, 20);
      if ($urandom_range(0, 3) == 0) send_seq(0, $urandom_range(1, 5), 1'b0, 1'b1, 20);
      send_seq(0, 64, 1'b1, 1'b1, $urandom_range(0, 40));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
